// File: rtl/riscv_du_rf_ctrl_if.sv
// Command/response channel between the debug transport bridge and the RF debug controller.
interface riscv_du_rf_ctrl_if #(parameter int XLEN = 32) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [11:0]     cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/riscv_du_rf_ctrl.sv
// Debug-unit RF port controller: stalls the core, performs one GPR read/write, returns a response.
// Optional write readback check enabled by defining RISCV_DU_RF_WRVERIFY_EN.
//
// state  | meaning
// IDLE   | waiting for a command; du_stall tracks dbg_hold
// STALL  | stall asserted, waiting for cpu_halted (or timeout / bad-address exit)
// ACCESS | single RF access cycle
// VERIFY | write readback compare (RISCV_DU_RF_WRVERIFY_EN only)
// RESP   | response held until rsp_ready
module riscv_du_rf_ctrl #(
  parameter int XLEN         = 32,
  parameter int AR_BITS      = 5,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  riscv_du_rf_ctrl_if.slave bus,
  input  logic             dbg_hold,
  input  logic             cpu_halted,
  output logic             du_stall,
  output logic             du_we_rf,
  output logic [11:0]      du_addr,
  output logic [XLEN-1:0]  du_dato,
  input  logic [XLEN-1:0]  du_dati_rf
);

  localparam int CNT_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT + 1);

`ifdef RISCV_DU_RF_WRVERIFY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_STALL, ST_ACCESS, ST_VERIFY, ST_RESP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_STALL, ST_ACCESS, ST_RESP} state_t;
`endif

  state_t          state;
  logic [CNT_W-1:0] tmr;
  logic            we_q;
  logic            bad_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;
  logic            cmd_bad;
  logic            idx_nz;

  assign cmd_bad = (bus.cmd_addr[11:AR_BITS] != '0);
  assign idx_nz  = (du_addr[AR_BITS-1:0] != '0);

  assign bus.cmd_ready = (state == ST_IDLE) & ~rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      du_stall    <= 1'b0;
      du_we_rf    <= 1'b0;
      du_addr     <= '0;
      du_dato     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          du_stall <= dbg_hold;
          if (bus.cmd_valid) begin
            du_addr <= bus.cmd_addr;
            du_dato <= bus.cmd_wdata;
            we_q    <= bus.cmd_we;
            bad_q   <= cmd_bad;
            tmr     <= CNT_W'(HALT_TIMEOUT - 1);
            // a bad address never stalls the core; du_stall keeps the dbg_hold value
            if (!cmd_bad) du_stall <= 1'b1;
            state   <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (bad_q || (!cpu_halted && tmr == '0)) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state       <= ST_RESP;
          end else if (cpu_halted) begin
            du_we_rf <= we_q & idx_nz;
            state    <= ST_ACCESS;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_ACCESS: begin
          du_we_rf <= 1'b0;
          if (!we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= du_dati_rf;
            rsp_err_q   <= 1'b0;
            state       <= ST_RESP;
          end else begin
`ifdef RISCV_DU_RF_WRVERIFY_EN
            state <= ST_VERIFY;
`else
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            state       <= ST_RESP;
`endif
          end
        end
`ifdef RISCV_DU_RF_WRVERIFY_EN
        ST_VERIFY: begin
          // x0 reads back as 0 by construction, so it is exempt from the compare
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= du_dati_rf;
          rsp_err_q   <= idx_nz && (du_dati_rf != du_dato);
          state       <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            du_stall    <= dbg_hold;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_du_rf_ctrl.sv
// Bench for riscv_du_rf_ctrl: directed scenarios plus randomized commands against an RF-content model.
module tb_riscv_du_rf_ctrl;
  localparam int XLEN = 32;
  localparam int HT   = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dbg_hold = 1'b0;
  logic        cpu_halted = 1'b1;
  logic        du_stall, du_we_rf;
  logic [11:0] du_addr;
  logic [31:0] du_dato, du_dati_rf;

  riscv_du_rf_ctrl_if #(.XLEN(XLEN)) bus ();

  riscv_du_rf_ctrl #(.XLEN(XLEN), .AR_BITS(5), .HALT_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_hold(dbg_hold), .cpu_halted(cpu_halted),
    .du_stall(du_stall), .du_we_rf(du_we_rf), .du_addr(du_addr), .du_dato(du_dato),
    .du_dati_rf(du_dati_rf)
  );

  always #5 clk = ~clk;

  // bench-side register file driven by the DUT's debug port
  logic [31:0] rf_mem [32];
  assign du_dati_rf = (du_addr[4:0] == 5'd0) ? 32'd0 : rf_mem[du_addr[4:0]];

  int          we_cnt = 0;
  logic [11:0] we_addr = '0;
  always @(posedge clk) begin
    if (du_we_rf) begin
      we_cnt++;
      we_addr = du_addr;
      rf_mem[du_addr[4:0]] <= du_dato;
    end
  end

  int   stall_low = 0;
  logic mon_en = 1'b0;
  always @(negedge clk) if (mon_en && !du_stall) stall_low++;

  // reference model: expected architectural register contents
  logic [31:0] exp_rf [32];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // hdly: cycle (relative to accept) at which cpu_halted is raised; 0 = already high
  task automatic run_cmd(input logic we, input logic [11:0] addr, input logic [31:0] wd, input int hdly);
    logic        bad, to, exp_err, exp_stall, stall_ok, done;
    int          idx, exp_lat, lat, w, we0, exp_we, k;
    logic [31:0] exp_rd, rd;
    bad = (addr[11:5] != 7'd0);
    idx = int'(addr[4:0]);
    to  = !bad && (hdly > HT);
    if (bad) begin
      exp_lat = 2; exp_err = 1'b1; exp_rd = 32'd0; exp_we = 0;
    end else if (to) begin
      exp_lat = HT + 1; exp_err = 1'b1; exp_rd = 32'd0; exp_we = 0;
    end else begin
      exp_lat = ((hdly < 1) ? 1 : hdly) + 2;
      exp_err = 1'b0;
      exp_we  = (we && idx != 0) ? 1 : 0;
      if (!we) exp_rd = (idx == 0) ? 32'd0 : exp_rf[idx];
      else begin
`ifdef RISCV_DU_RF_WRVERIFY_EN
        exp_lat = exp_lat + 1;
        exp_rd  = (idx == 0) ? 32'd0 : wd;
`else
        exp_rd  = 32'd0;
`endif
      end
    end
    exp_stall = bad ? dbg_hold : 1'b1;

    @(negedge clk);
    cpu_halted = (hdly == 0);
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = addr; bus.cmd_wdata = wd;
    w = 0;
    while (!bus.cmd_ready && w < 10) begin @(negedge clk); w++; end
    chk("cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    we0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1; stall_ok = 1'b1; done = 1'b0;
    while (!done) begin
      if (du_stall !== exp_stall) stall_ok = 1'b0;
      if (lat == hdly) cpu_halted = 1'b1;
      if (bus.rsp_valid || lat >= 400) done = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    chk("latency", lat, exp_lat);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
    chk("stall_during_cmd", {31'd0, stall_ok}, 32'd1);
    rd = bus.rsp_rdata;
    k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("rsp_valid_held", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rsp_rdata_stable", bus.rsp_rdata, rd);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
    chk("stall_after_rsp", {31'd0, du_stall}, {31'd0, dbg_hold});
    chk("we_pulses", we_cnt - we0, exp_we);
    if (exp_we == 1) chk("we_addr", {20'd0, we_addr}, {20'd0, addr});
    if (exp_we == 1) exp_rf[idx] = wd;
  endtask

  initial begin
    logic [31:0] v;
    int          hi, lo, hd;
    logic        rw;
    logic [11:0] a;

    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    rf_mem[0] = 32'd0; exp_rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      v = $urandom; rf_mem[i] = v; exp_rf[i] = v;
    end
    rf_mem[5] = 32'hDEADBEEF; exp_rf[5] = 32'hDEADBEEF;

    // reset state
    #1;
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_du_stall", {31'd0, du_stall}, 32'd0);
    chk("rst_du_outs", {du_we_rf, 7'd0, du_addr, 12'd0} | du_dato, 32'd0);
    chk("rst_rsp_data", bus.rsp_rdata | {31'd0, bus.rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // basic read / write / x0
    run_cmd(1'b0, 12'h005, 32'd0, 0);
    run_cmd(1'b1, 12'h00A, 32'h12345678, 0);
    run_cmd(1'b0, 12'h00A, 32'd0, 0);
    run_cmd(1'b1, 12'h000, 32'hFFFFFFFF, 0);
    run_cmd(1'b0, 12'h000, 32'd0, 0);

    // halt timeout
    run_cmd(1'b0, 12'h003, 32'd0, 100000);

    // bad address, then back-to-back reads under dbg_hold
    run_cmd(1'b0, 12'h120, 32'd0, 0);
    dbg_hold = 1'b1;
    repeat (2) @(negedge clk);
    stall_low = 0; mon_en = 1'b1;
    run_cmd(1'b0, 12'h005, 32'd0, 0);
    run_cmd(1'b0, 12'h00A, 32'd0, 0);
    mon_en = 1'b0;
    chk("hold_stall_continuous", stall_low, 0);
    dbg_hold = 1'b0;

    // delayed halt acknowledge
    run_cmd(1'b0, 12'h007, 32'd0, 3);
    run_cmd(1'b1, 12'h011, 32'hA5A55A5A, 5);
    run_cmd(1'b0, 12'h011, 32'd0, 1);

    // reset during the ACCESS cycle of a write
    @(negedge clk);
    cpu_halted = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 12'h00C; bus.cmd_wdata = 32'hCAFEF00D;
    chk("rstw_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstw_access_we", {31'd0, du_we_rf}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_we", {31'd0, du_we_rf}, 32'd0);
    chk("rstw_stall", {31'd0, du_stall}, 32'd0);
    chk("rstw_addr", {20'd0, du_addr}, 32'd0);
    chk("rstw_dato", du_dato, 32'd0);
    chk("rstw_rsp", {30'd0, bus.rsp_valid, bus.rsp_err} | bus.rsp_rdata, 32'd0);
    chk("rstw_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    run_cmd(1'b0, 12'h000, 32'd0, 0);
    run_cmd(1'b0, 12'h00C, 32'd0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(0, 1));
      lo = $urandom_range(0, 7);
      if ($urandom_range(0, 5) == 0) begin
        hi = $urandom_range(1, 127);
        a  = {hi[6:0], lo[4:0]};
      end else begin
        a = {7'd0, lo[4:0]};
      end
      hd = $urandom_range(0, 5);
      dbg_hold = 1'($urandom_range(0, 1));
      run_cmd(rw, a, $urandom, hd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/riscv_du_rf_ctrl.md
Name: riscv_du_rf_ctrl

Overview:
Debug-unit side controller for the register file debug port. It accepts single-word register read/write commands from the debug transport (JTAG/UART bridge) over a valid/ready command channel. For each command it stalls the core, waits for the pipeline-halted acknowledge, then drives the RF debug address, write-data and write-enable lines. It returns read data and status on a valid/ready response channel.

Parameters:
XLEN, 32, data width; matches the RF debug data width
AR_BITS, 5, RF index width
HALT_TIMEOUT, 255, cycles to wait for cpu_halted before aborting; minimum 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  12  debug address; GPR region is 0x000-0x01F
cmd_wdata  in  XLEN  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  XLEN  read data
rsp_err  out  1  1 = timeout or bad address
dbg_hold  in  1  keep core stalled between commands
cpu_halted  in  1  core pipeline halted acknowledge
du_stall  out  1  stall request to core
du_we_rf  out  1  RF debug write enable
du_addr  out  12  RF debug address
du_dato  out  XLEN  RF debug write data
du_dati_rf  in  XLEN  RF debug read data; combinational from du_addr

Behaviour:
- FSM states: IDLE, STALL, ACCESS, VERIFY (macro only), RESP. Reset state is IDLE.
- Reset values: du_stall=0, du_we_rf=0, du_addr=0, du_dato=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. cmd_ready=0 while rst is high.
- All outputs are registered, except cmd_ready = (state==IDLE) & ~rst.
- IDLE:
  - du_stall follows dbg_hold, registered.
  - On cmd accept: latch cmd_addr into du_addr, cmd_wdata into du_dato, cmd_we internally; go to STALL.
- Address check at accept: cmd_addr[11:AR_BITS] != 0 is a bad address. Next state is RESP with rsp_err=1 and rsp_rdata=0. du_stall is not asserted for this command; no RF access.
- STALL:
  - du_stall=1.
  - Timeout counter is cleared on entry and increments each cycle cpu_halted=0.
  - cpu_halted=1 goes to ACCESS.
  - Counter reaching HALT_TIMEOUT goes to RESP with rsp_err=1, rsp_rdata=0, no RF access.
- ACCESS (exactly one cycle):
  - Write to a nonzero index: du_we_rf=1 this cycle only.
  - Write to x0: du_we_rf stays 0 and the write is silently dropped; rsp_err=0.
  - Read: sample du_dati_rf at the end of the cycle into rsp_rdata. x0 reads return 0, because the RF masks index 0.
  - Next state is RESP, or VERIFY for writes when the macro is enabled.
- RESP:
  - rsp_valid=1 and held, with rsp_rdata and rsp_err stable, until rsp_ready=1.
  - Write responses return rsp_rdata=0.
  - On handshake go to IDLE; du_stall drops the next cycle unless dbg_hold=1.
- Latency: read accepted in cycle T with cpu_halted already 1 gives STALL T+1, ACCESS T+2, rsp_valid T+3.
- Only one command is outstanding; no new cmd is accepted until the response handshake completes.
- dbg_hold changes mid-command have no effect until IDLE.
- du_stall is never deasserted between STALL and RESP handshake.
- cpu_halted falling during ACCESS is ignored; the access completes.
- Async reset mid-operation aborts immediately, returns all outputs to reset values, and discards the pending response.

Optional Feature:
RISCV_DU_RF_WRVERIFY_EN
- Defined: a write proceeds ACCESS -> VERIFY (one cycle, du_we_rf=0, du_addr unchanged) -> RESP.
  - VERIFY samples du_dati_rf into rsp_rdata.
  - rsp_err=1 if readback differs from du_dato. Writes to x0 are exempt: readback 0, err=0.
  - Write latency is one cycle longer.
- Undefined: no VERIFY state; write responses return rsp_rdata=0 and rsp_err=0.

Test Plan:
- Reset then idle, with cpu_halted tied 1: read cmd_addr=0x005 while the RF holds x5=0xDEADBEEF -> rsp_valid at T+3, rsp_rdata=0xDEADBEEF, rsp_err=0, du_stall high T+1..T+3 then low.
- Write cmd_addr=0x00A, wdata=0x12345678 -> du_we_rf high exactly one cycle with du_addr=0x00A; a subsequent read returns 0x12345678. With macro: rsp_rdata=0x12345678, err=0.
- Write x0=0xFFFFFFFF -> du_we_rf never asserts; read x0 returns 0.
- cpu_halted held 0, HALT_TIMEOUT=255 -> after 255 STALL cycles: rsp_err=1, rsp_rdata=0, no du_we_rf pulse, du_stall low after handshake.
- cmd_addr=0x120 -> error response 2 cycles after accept, du_stall never asserted. Then dbg_hold=1 with two back-to-back reads -> du_stall stays high continuously across both commands.
- Assert rst during ACCESS of a write -> all outputs 0 next edge; after release, cmd_ready=1 and a fresh read completes normally with rsp_rdata 0 for x0.
